// File: rtl/hex_multi_display.sv
`default_nettype none
// ============================================================================
//  Module   : hex_multi_display
//  Purpose  : Registered multi-digit seven-segment driver. Captures a value on
//             a load handshake and shows it in hex or decimal (double-dabble)
//             with optional leading-zero blanking and decimal overflow dashes.
//             Segments are active-low, gfedcba ordering.
//  Revision : 1.0  initial release
// ============================================================================
module hex_multi_display #(
    parameter int NUM_DIGITS = 6,
    parameter int WIDTH      = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             value,
    input  logic                         load,
    input  logic                         dec_mode,
    input  logic                         blank_lz,
    output logic                         ready,
    output logic                         done,
    output logic                         ovf,
    output logic [NUM_DIGITS-1:0][6:0]   hex
);

    // Two spare BCD nibbles above the displayed ones make overflow visible.
    localparam int NIBBLES = NUM_DIGITS + 2;
    localparam int BCD_W   = 4 * NIBBLES;
    localparam int DISP_W  = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(WIDTH + 1);

    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || WIDTH < 1 || WIDTH > 4 * NUM_DIGITS) begin : g_bad_params
            $error("hex_multi_display: illegal NUM_DIGITS/WIDTH combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t                          state;
    logic [WIDTH-1:0]                data;      // captured value, doubles as the dabble shift register
    logic [BCD_W-1:0]                bcd;
    logic [CNT_W-1:0]                cnt;
    logic                            dec_r;
    logic                            blank_r;

    logic [BCD_W-1:0]                bcd_adj;
    logic [BCD_W-1:0]                bcd_step;
    logic [WIDTH-1:0]                data_step;
    logic [DISP_W-1:0]               disp;
    logic                            over;
    logic                            seen;
    logic [3:0]                      nib;
    logic [NUM_DIGITS-1:0][6:0]      pat;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, data} left.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NIBBLES; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcd_step, data_step} = {bcd_adj, data} << 1;
    end

    // Digit source selection, overflow detection and blanking for the commit.
    always_comb begin
        disp = '0;
        if (dec_r) begin
            disp = bcd[DISP_W-1:0];
        end else begin
            disp[WIDTH-1:0] = data;
        end
        over = dec_r && (|bcd[BCD_W-1:DISP_W]);
        seen = 1'b0;
        nib  = 4'd0;
        pat  = '0;
        // Scan from the most significant digit so 'seen' marks the first nonzero one.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib  = disp[4*i +: 4];
            seen = seen | (nib != 4'd0);
            if (over) begin
                pat[i] = SEG_DASH;
            end else if (blank_r && !seen && i != 0) begin
                pat[i] = SEG_BLANK;
            end else begin
                pat[i] = seg7(nib);
            end
        end
    end

    // Control FSM with registered handshake and display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            data    <= '0;
            bcd     <= '0;
            cnt     <= '0;
            dec_r   <= 1'b0;
            blank_r <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            ovf     <= 1'b0;
            hex     <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        data    <= value;
                        dec_r   <= dec_mode;
                        blank_r <= blank_lz;
                        ready   <= 1'b0;
                        if (dec_mode) begin
                            state <= CONVERT;
                            cnt   <= CNT_INIT;
                            bcd   <= '0;
                        end else begin
                            state <= COMMIT;
                        end
                    end
                end
                CONVERT: begin
                    bcd  <= bcd_step;
                    data <= data_step;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    hex   <= pat;
                    ovf   <= over;
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
